norm_pipeline_sequencer: RTL

//  Frame-level controller for the crop_filter -> norm_reader chain. Accepts one frame request
//  at a time, pulses ap_start to both stages, latches the crop stage's per-frame max pixel as
//  the normalization denominator, and waits for norm-stage completion. Adds a watchdog timeout,
//  a frame counter and a single-cycle frame_done strobe for the host/control side.

---
 rtl/norm_pipeline_sequencer_pkg.sv | 20 ++
 rtl/norm_pipeline_sequencer_if.sv | 44 ++++
 rtl/norm_pipeline_sequencer_watchdog.sv | 33 +++
 rtl/norm_pipeline_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/norm_pipeline_sequencer_pkg.sv
// norm_pipe_pkg: shared types and constants for the crop_filter -> norm_reader
// frame sequencer.
//   PIX_W           - pixel / denominator width
//   DEFAULT_TIMEOUT - default watchdog budget in clock cycles
//   seq_state_t     - sequencer FSM states
package norm_pipe_pkg;

    localparam int PIX_W           = 8;
    localparam int DEFAULT_TIMEOUT = 1048576;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_CROP,
        S_NORM,
        S_DONE,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/norm_pipeline_sequencer_if.sv
// norm_pipeline_sequencer_if: host request/status signals plus the ap_ctrl
// handshakes of the crop and norm stages, bundled for the sequencer.
//   master - sequencer side (drives start pulses, denominator, status)
//   slave  - host/stage side (drives request, ready/done, max value, err_clear)
interface norm_pipeline_sequencer_if #(
    parameter int FRAME_CNT_W = 16
);
    import norm_pipe_pkg::*;

    logic                   frame_req;
    logic                   frame_req_ready;
    logic                   cf_ap_start;
    logic                   cf_ap_ready;
    logic                   cf_ap_done;
    logic [PIX_W-1:0]       cf_max_value;
    logic                   nr_ap_start;
    logic                   nr_ap_ready;
    logic                   nr_ap_done;
    logic                   seq_ap_idle;
    logic [PIX_W-1:0]       norm_denominator;
    logic                   norm_denominator_tvalid;
    logic                   busy;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   timeout_err;
    logic                   err_clear;

    modport master (
        input  frame_req, cf_ap_ready, cf_ap_done, cf_max_value,
               nr_ap_ready, nr_ap_done, err_clear,
        output frame_req_ready, cf_ap_start, nr_ap_start, seq_ap_idle,
               norm_denominator, norm_denominator_tvalid, busy,
               frame_done, frame_count, timeout_err
    );

    modport slave (
        output frame_req, cf_ap_ready, cf_ap_done, cf_max_value,
               nr_ap_ready, nr_ap_done, err_clear,
        input  frame_req_ready, cf_ap_start, nr_ap_start, seq_ap_idle,
               norm_denominator, norm_denominator_tvalid, busy,
               frame_done, frame_count, timeout_err
    );

endinterface

// File: rtl/norm_pipeline_sequencer_watchdog.sv
// seq_watchdog: cycle counter bounding one frame's time in flight.
//   clk, reset - clock, synchronous active-high reset
//   clear      - zero the counter (frame launch)
//   enable     - count this cycle (frame in flight)
//   expired    - budget of TIMEOUT_CYCLES-1 counted cycles reached while enabled
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LIMIT so expiry stays asserted even if the FSM defers it
    // by a cycle (e.g. a crop completion taking priority).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/norm_pipeline_sequencer.sv
// norm_pipeline_sequencer: frame-level controller for crop_filter -> norm_reader.
// Launches both stages with one-cycle start pulses, latches the crop stage's
// frame max as the (non-zero) normalization denominator, waits for the norm
// stage, and reports completion, frame count and a sticky watchdog error.
//   clk, reset - clock, synchronous active-high reset
//   bus        - master modport of norm_pipeline_sequencer_if
// All bus outputs are registered except frame_req_ready and seq_ap_idle.
module norm_pipeline_sequencer
    import norm_pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    norm_pipeline_sequencer_if.master  bus
);

    // A zero max would make the norm stage divide by zero; clamp to 1.
    function automatic logic [PIX_W-1:0] safe_denom(input logic [PIX_W-1:0] v);
        return (v == '0) ? PIX_W'(1) : v;
    endfunction

    seq_state_t state, next_state;
    logic       wd_expired;
    logic       launch_go;
    logic       start_nxt, latch_nxt, done_nxt, err_set, busy_nxt;

    logic                   cf_start_q, nr_start_q;
    logic [PIX_W-1:0]       denom_q;
    logic                   tvalid_q, busy_q, done_q, err_q;
    logic [FRAME_CNT_W-1:0] count_q;

    seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == S_IDLE && bus.frame_req),
        .enable  (state == S_LAUNCH || state == S_CROP || state == S_NORM),
        .expired (wd_expired)
    );

    assign launch_go = (state == S_LAUNCH) && bus.cf_ap_ready && bus.nr_ap_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (bus.frame_req) next_state = S_LAUNCH;
            S_LAUNCH: begin
                if (launch_go)       next_state = S_CROP;
                else if (wd_expired) next_state = S_ERR;
            end
            S_CROP: begin
                if (bus.cf_ap_done)  next_state = bus.nr_ap_done ? S_DONE : S_NORM;
                else if (wd_expired) next_state = S_ERR;
            end
            S_NORM: begin
                if (bus.nr_ap_done)  next_state = S_DONE;
                else if (wd_expired) next_state = S_ERR;
            end
            S_DONE:   next_state = S_IDLE;
            S_ERR:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from next_state so they line up with the
    // state they describe (busy/frame_done/timeout_err change with the state).
    always_comb begin
        start_nxt = launch_go;
        latch_nxt = (state == S_CROP) && bus.cf_ap_done;
        done_nxt  = (next_state == S_DONE);
        err_set   = (next_state == S_ERR);
        busy_nxt  = (next_state == S_LAUNCH) || (next_state == S_CROP) ||
                    (next_state == S_NORM)   || (next_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cf_start_q <= 1'b0;
            nr_start_q <= 1'b0;
            denom_q    <= PIX_W'(1);
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            cf_start_q <= start_nxt;
            nr_start_q <= start_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            if (done_nxt) count_q <= count_q + 1'b1;
            // Denominator value is held; only its valid flag drops on relaunch/error.
            if (latch_nxt) begin
                denom_q  <= safe_denom(bus.cf_max_value);
                tvalid_q <= 1'b1;
            end else if (start_nxt || err_set) begin
                tvalid_q <= 1'b0;
            end
            if (err_set)            err_q <= 1'b1;
            else if (bus.err_clear) err_q <= 1'b0;
        end
    end

    assign bus.frame_req_ready         = (state == S_IDLE);
    assign bus.seq_ap_idle             = (state == S_IDLE) || (state == S_LAUNCH);
    assign bus.cf_ap_start             = cf_start_q;
    assign bus.nr_ap_start             = nr_start_q;
    assign bus.norm_denominator        = denom_q;
    assign bus.norm_denominator_tvalid = tvalid_q;
    assign bus.busy                    = busy_q;
    assign bus.frame_done              = done_q;
    assign bus.frame_count             = count_q;
    assign bus.timeout_err             = err_q;

endmodule
